// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard/sequencing controller: per-register in-flight scoreboard, RAW stall, branch flush, HLT drain.
// Optional build macro WB_BYPASS_EN: a register retiring this cycle counts as ready (write-before-read regfile).
module pipe_hazard_ctl #(
  parameter int NREG         = 8,
  parameter int RW           = 3,
  parameter int CNT_W        = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [RW-1:0]   id_rs,
  input  logic            id_rs_use,
  input  logic [RW-1:0]   id_rt,
  input  logic            id_rt_use,
  input  logic            id_regwrite,
  input  logic [RW-1:0]   id_rd,
  input  logic            id_halt,
  input  logic            wb_regwrite,
  input  logic [RW-1:0]   wb_rd,
  input  logic            br_taken,
  output logic            pc_we,
  output logic            ifid_we,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic            halted,
  output logic [NREG-1:0] pending
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]    DLAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CMAX  = '1;

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt [NREG];
  logic [DW-1:0]    drain_cnt;
  logic [NREG-1:0]  busy, inc, dec;
  logic             raw, issue, scb_empty;

  always_comb begin
    busy    = '0;
    dec     = '0;
    pending = '0;
    for (int i = 0; i < NREG; i++) begin
      pending[i] = (cnt[i] != '0);
      dec[i]     = wb_regwrite & (wb_rd == RW'(i));
`ifdef WB_BYPASS_EN
      busy[i]    = pending[i] & ~((cnt[i] == CNT_W'(1)) & dec[i]);
`else
      busy[i]    = pending[i];
`endif
    end
  end

  assign raw       = id_valid & ((id_rs_use & busy[id_rs]) | (id_rt_use & busy[id_rt]));
  assign issue     = (state == RUN) & id_valid & ~raw & ~br_taken & ~id_halt;
  assign scb_empty = ~|pending;

  always_comb begin
    inc = '0;
    for (int i = 0; i < NREG; i++)
      inc[i] = issue & id_regwrite & (id_rd == RW'(i));
  end

  // Simultaneous issue and retire on the same register cancel; saturate at both ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (inc[i] & ~dec[i] & (cnt[i] != CMAX))
          cnt[i] <= cnt[i] + 1'b1;
        else if (dec[i] & ~inc[i] & (cnt[i] != '0))
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    case (state)
      RUN: begin
        if (br_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (raw | (id_valid & id_halt)) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      default: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      drain_cnt <= '0;
      halted    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (id_valid & id_halt & ~br_taken & ~raw) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          // Hold at the last count until every in-flight write has retired.
          if (drain_cnt == DLAST) begin
            if (scb_empty) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        HALT:    halted <= 1'b1;
        default: state  <= RUN;
      endcase
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_cnt_chk
    assert property (@(posedge clk) disable iff (!rst_n) !(dec[g] && !inc[g] && cnt[g] == '0));
    assert property (@(posedge clk) disable iff (!rst_n) !(inc[g] && !dec[g] && cnt[g] == CMAX));
  end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Self-checking bench for pipe_hazard_ctl: directed scenarios plus randomized traffic against a scoreboard model.
module tb_pipe_hazard_ctl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs_use, id_rt_use, id_regwrite, id_halt, wb_regwrite, br_taken;
  logic [2:0] id_rs, id_rt, id_rd, wb_rd;
  logic       pc_we, ifid_we, ifid_flush, idex_bubble, halted;
  logic [7:0] pending;

  pipe_hazard_ctl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_use(id_rs_use),
    .id_rt(id_rt), .id_rt_use(id_rt_use), .id_regwrite(id_regwrite), .id_rd(id_rd),
    .id_halt(id_halt), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .br_taken(br_taken),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .halted(halted), .pending(pending)
  );

  always #5 clk = ~clk;

  int mcnt [8];
  int mstate;   // 0 running, 1 draining, 2 halted
  int mdrain;
  bit mhalted;
  int tests = 0, failed = 0;
  logic last_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) mcnt[i] = 0;
    mstate = 0; mdrain = 0; mhalted = 0;
  endtask

  function automatic bit m_busy(input int r);
    if (mcnt[r] == 0) return 1'b0;
`ifdef WB_BYPASS_EN
    if (mcnt[r] == 1 && wb_regwrite && wb_rd == r) return 1'b0;
`endif
    return 1'b1;
  endfunction

  // Drives one cycle starting just after a rising edge; checks outputs mid-cycle, then advances the model.
  task automatic step(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                      input bit rw, input int rd, input bit hlt, input bit wbw, input int wbrd,
                      input bit br);
    bit m_raw, m_issue, e_pc, e_if, e_fl, e_bub, all_zero;
    logic [7:0] e_pend;
    int ncnt [8];
    id_valid = v; id_rs = 3'(rs); id_rs_use = rsu; id_rt = 3'(rt); id_rt_use = rtu;
    id_regwrite = rw; id_rd = 3'(rd); id_halt = hlt; wb_regwrite = wbw; wb_rd = 3'(wbrd);
    br_taken = br;
    #3;
    m_raw = v && ((rsu && m_busy(rs)) || (rtu && m_busy(rt)));
    if (mstate != 0)           {e_pc, e_if, e_fl, e_bub} = 4'b0001;
    else if (br)               {e_pc, e_if, e_fl, e_bub} = 4'b1111;
    else if (m_raw || (v && hlt)) {e_pc, e_if, e_fl, e_bub} = 4'b0001;
    else                       {e_pc, e_if, e_fl, e_bub} = 4'b1100;
    all_zero = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e_pend[i] = (mcnt[i] != 0);
      if (mcnt[i] != 0) all_zero = 1'b0;
    end
    chk("pc_we", 32'(pc_we), 32'(e_pc));
    chk("ifid_we", 32'(ifid_we), 32'(e_if));
    chk("ifid_flush", 32'(ifid_flush), 32'(e_fl));
    chk("idex_bubble", 32'(idex_bubble), 32'(e_bub));
    chk("pending", 32'(pending), 32'(e_pend));
    chk("halted", 32'(halted), 32'(mhalted));
    last_pc = pc_we;
    m_issue = (mstate == 0) && v && !m_raw && !br && !hlt;
    for (int i = 0; i < 8; i++) begin
      bit up, dn;
      up = m_issue && rw && rd == i;
      dn = wbw && wbrd == i;
      ncnt[i] = mcnt[i];
      if (up && !dn && mcnt[i] < 3) ncnt[i] = mcnt[i] + 1;
      if (dn && !up && mcnt[i] > 0) ncnt[i] = mcnt[i] - 1;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) mcnt[i] = ncnt[i];
    if (mstate == 0) begin
      if (v && hlt && !br && !m_raw) begin mstate = 1; mdrain = 0; end
    end else if (mstate == 1) begin
      if (mdrain == 2) begin
        if (all_zero) begin mstate = 2; mhalted = 1; end
      end else mdrain++;
    end
  endtask

  task automatic nop(input bit wbw, input int wbrd, input bit br);
    step(0, 0, 0, 0, 0, 0, 0, 0, wbw, wbrd, br);
  endtask

  task automatic drain_scoreboard();
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 4; k++)
        if (mcnt[r] > 0) nop(1, r, 0);
  endtask

  initial begin
    int stalls, n, wr, rd, v, rw;
    rst_n = 1'b0;
    id_valid = 0; id_rs = 0; id_rs_use = 0; id_rt = 0; id_rt_use = 0; id_regwrite = 0;
    id_rd = 0; id_halt = 0; wb_regwrite = 0; wb_rd = 0; br_taken = 0;
    m_reset();
    #2;
    chk("rst_pc_we", 32'(pc_we), 32'd1);
    chk("rst_ifid_we", 32'(ifid_we), 32'd1);
    chk("rst_flush", 32'(ifid_flush), 32'd0);
    chk("rst_bubble", 32'(idex_bubble), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Write r3, then a reader of r3 stalls until the write retires three cycles later.
    step(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    stalls = 0;
    for (int c = 1; c <= 10; c++) begin
      step(1, 3, 1, 0, 0, 0, 0, 0, c == 3, 3, 0);
      if (last_pc == 1'b0) stalls++;
      else break;
    end
`ifdef WB_BYPASS_EN
    chk("raw_stall_count", 32'(stalls), 32'd2);
`else
    chk("raw_stall_count", 32'(stalls), 32'd3);
`endif

    // Three writes to r5 then three retires.
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    nop(1, 5, 0); nop(1, 5, 0);
    chk("r5_pending_before_last", 32'(pending[5]), 32'd1);
    nop(1, 5, 0);
    chk("r5_pending_after_last", 32'(pending[5]), 32'd0);

    // Branch taken while a RAW hazard is present: flush wins, nothing issues.
    step(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
    step(1, 4, 1, 4, 1, 1, 6, 0, 0, 0, 1);
    chk("br_no_issue_r6", 32'(pending[6]), 32'd0);
    nop(1, 4, 0);

    // Issue and retire r2 in the same cycle with one write in flight.
    step(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 2, 0, 1, 2, 0);
    nop(1, 2, 0);
    chk("r2_cancel_then_empty", 32'(pending[2]), 32'd0);

    // Randomized traffic, no HLT.
    for (int c = 0; c < 400; c++) begin
      v  = ($urandom % 4) != 0;
      rw = $urandom % 2;
      rd = $urandom % 8;
      if (mcnt[rd] >= 3) rw = 0;
      wr = -1;
      if ($urandom % 2) begin
        int s;
        s = $urandom % 8;
        for (int k = 0; k < 8; k++)
          if (wr < 0 && mcnt[(s + k) % 8] > 0) wr = (s + k) % 8;
      end
      step(v[0], $urandom % 8, $urandom % 2, $urandom % 8, $urandom % 2, rw[0], rd, 0,
           wr >= 0, (wr >= 0) ? wr : 0, ($urandom % 8) == 0);
    end
    drain_scoreboard();
    chk("scoreboard_drained", 32'(pending), 32'd0);

    // HLT with empty scoreboard: three drain cycles, halted on the fourth; branches ignored.
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    n = 0;
    while (halted !== 1'b1 && n < 10) begin
      nop(0, 0, n[0]);
      n++;
    end
    chk("halt_latency", 32'(n), 32'd3);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
    chk("halt_sticky", 32'(halted), 32'd1);

    // Reset out of HALT, then build a drain that is held by two in-flight writes to r1.
    #2; rst_n = 1'b0; m_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) nop(0, 0, 1);
    chk("drain_held", 32'(halted), 32'd0);
    id_valid = 0; br_taken = 0; wb_regwrite = 0;
    #2; rst_n = 1'b0; #1;
    chk("async_rst_pc_we", 32'(pc_we), 32'd1);
    chk("async_rst_halted", 32'(halted), 32'd0);
    chk("async_rst_pending", 32'(pending), 32'd0);
    m_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 1, 1, 0, 0, 1, 7, 0, 0, 0, 0);
    nop(1, 7, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
